// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use and mult/div decode stalls, memory-wait freeze with
// timeout, and exception flush. Outputs are combinational on registered state and inputs.
module pipe_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic ld_use_hz,
  input  logic md_use_D,
  input  logic md_start,
  input  logic md_is_div,
  input  logic mem_req,
  input  logic mem_ack,
  input  logic int_req,
  output logic pc_en,
  output logic IF_ID_en,
  output logic ID_EX_en,
  output logic EX_MEM_en,
  output logic MEM_WB_en,
  output logic ID_EX_clr,
  output logic int_clr,
  output logic md_busy,
  output logic bus_err
);

  localparam int unsigned MdMax = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int unsigned MdW   = ($clog2(MdMax + 1) > 4) ? $clog2(MdMax + 1) : 4;
  localparam logic [7:0]  WaitLast = 8'(TIMEOUT - 1);

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  state_e         state_q, state_d;
  logic [MdW-1:0] md_cnt_q, md_cnt_d;
  logic [7:0]     wait_cnt_q, wait_cnt_d;

  logic timeout_hit;
  logic mem_stall;
  logic md_busy_int;
  logic stall_d;
  logic md_accept;

  always_comb begin
    timeout_hit = (state_q == StMemWait) && (wait_cnt_q == WaitLast);
    mem_stall   = mem_req & ~mem_ack & ~timeout_hit;
    md_busy_int = (md_cnt_q != '0);
    stall_d     = ld_use_hz | (md_use_D & md_busy_int);
  end

  // Priority: reset, memory freeze, exception flush, decode stall, normal flow.
  always_comb begin
    pc_en     = 1'b1;
    IF_ID_en  = 1'b1;
    ID_EX_en  = 1'b1;
    EX_MEM_en = 1'b1;
    MEM_WB_en = 1'b1;
    ID_EX_clr = 1'b0;
    int_clr   = 1'b0;
    if (reset) begin
      // Reset cycle: pass-through outputs, every other input ignored.
    end else if (mem_stall) begin
      pc_en     = 1'b0;
      IF_ID_en  = 1'b0;
      ID_EX_en  = 1'b0;
      EX_MEM_en = 1'b0;
      MEM_WB_en = 1'b0;
    end else if (int_req) begin
      int_clr = 1'b1;
    end else if (stall_d) begin
      pc_en     = 1'b0;
      IF_ID_en  = 1'b0;
      ID_EX_clr = 1'b1;
    end
  end

  always_comb begin
    md_busy   = ~reset & md_busy_int;
    bus_err   = ~reset & timeout_hit & ~mem_ack;
    md_accept = ~reset & md_start & EX_MEM_en & ~int_clr;
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          state_d    = StMemWait;
          wait_cnt_d = 8'd0;
        end
      end
      StMemWait: begin
        if (mem_ack || timeout_hit) begin
          state_d    = StRun;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = StRun;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  // A new start overwrites any operation in flight; otherwise count down to zero.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (md_accept) begin
      md_cnt_d = md_is_div ? MdW'(DIV_LAT) : MdW'(MULT_LAT);
    end else if (md_busy_int) begin
      md_cnt_d = md_cnt_q - {{(MdW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StRun;
      md_cnt_q   <= '0;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      md_cnt_q   <= md_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule
